// File: rtl/wb_timer_slave_pkg.sv
// Shared types and constants for the wishbone machine-timer slave.
// Holds the wishbone bundle types, the register offset map, the ctrl
// field positions and the byte-lane merge helper used by register writes.
package wb_timer_slave_pkg;

  // Master-to-slave wishbone bundle
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
  } wb_m2s_t;

  // Slave-to-master wishbone bundle
  typedef struct packed {
    logic [31:0] data;
    logic        ack;
  } wb_s2m_t;

  // Register offsets, word index taken from addr[4:2]
  localparam logic [2:0] TMR_OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] TMR_OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] TMR_OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] TMR_OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] TMR_OFF_CTRL     = 3'd4;

  // Ctrl register field positions
  localparam int TMR_CTRL_EN      = 0;
  localparam int TMR_CTRL_DIV_LSB = 8;

  // Default bus base address (32-byte aligned)
  localparam logic [31:0] TMR_BASE = 32'h0200_0000;

  // Replace the byte lanes of old_w selected by sel with those of new_w
  function automatic logic [31:0] wb_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        r[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        r[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the machine timer: counts 0..div while enabled and
// emits a one-cycle tick on the cycle the count equals div.
// A clear forces the count back to zero on the next edge.
module timer_prescaler
  import wb_timer_slave_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_enable,
  input  logic [PRESCALE_W-1:0] i_div,
  input  logic                  i_clear,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;
  logic                  hit_s;

  assign hit_s  = (cnt_q == i_div);
  // Tick is combinational so mtime advances on the same edge the count wraps
  assign o_tick = i_enable & hit_s;

  // Next count: clear wins, otherwise wrap at div while enabled, else hold
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable) begin
      if (hit_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_timer_slave.sv
// Wishbone single-beat slave holding a 64-bit machine timer (mtime),
// a 64-bit compare (mtimecmp) and a ctrl register (enable, prescaler div).
// Drives a registered level interrupt when enabled and mtime >= mtimecmp.
// Optional macro TIMER_SNAPSHOT_EN: a read of mtime_lo latches mtime_hi
// into a shadow returned by the next mtime_hi read (coherent 64-bit read).
module wb_timer_slave
  import wb_timer_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = TMR_BASE,
  parameter int          PRESCALE_W = 8
) (
  input  logic    i_clk,
  input  logic    i_rstn,
  input  wb_m2s_t i_wb,
  output wb_s2m_t o_wb,
  output logic    o_irq
);

  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           cmp_q, cmp_d;
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [31:0]           data_q, data_d;
  logic                  ack_q, ack_d;
  logic                  irq_q, irq_d;
`ifdef TIMER_SNAPSHOT_EN
  logic [31:0]           shadow_q, shadow_d;
`endif

  logic                  sel_hit_s;
  logic                  ack_next_s;
  logic                  wr_s;
  logic                  wr_any_s;
  logic                  ctrl_wr_s;
  logic [2:0]            off_s;
  logic [31:0]           ctrl_word_s;
  logic [31:0]           ctrl_new_s;
  logic [31:0]           rd_data_s;
  logic                  tick_s;
  logic                  unused_ok_s;

  assign sel_hit_s  = i_wb.cyc & i_wb.stb & (i_wb.addr[31:5] == BASE_ADDR[31:5]);
  // The ~ack term keeps a held stb from being acked twice in a row
  assign ack_next_s = sel_hit_s & ~ack_q;
  assign off_s      = i_wb.addr[4:2];
  assign wr_s       = ack_next_s & i_wb.we;
  assign wr_any_s   = wr_s & (|i_wb.sel);
  assign ctrl_wr_s  = wr_s & (off_s == TMR_OFF_CTRL);

  // Byte address bits and unimplemented ctrl bits are intentionally ignored
  assign unused_ok_s = ^{i_wb.addr[1:0], ctrl_new_s};

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_enable (en_q),
    .i_div    (div_q),
    .i_clear  (ctrl_wr_s),
    .o_tick   (tick_s)
  );

  // Assemble the ctrl word as seen by the bus and the result of a write to it
  always_comb begin
    ctrl_word_s = 32'd0;
    ctrl_word_s[TMR_CTRL_EN] = en_q;
    ctrl_word_s[TMR_CTRL_DIV_LSB +: PRESCALE_W] = div_q;
    ctrl_new_s = wb_merge(ctrl_word_s, i_wb.data, i_wb.sel);
  end

  // Read mux over current register values; reserved offsets read zero
  always_comb begin
    rd_data_s = 32'd0;
    case (off_s)
      TMR_OFF_MTIME_LO: rd_data_s = mtime_q[31:0];
`ifdef TIMER_SNAPSHOT_EN
      TMR_OFF_MTIME_HI: rd_data_s = shadow_q;
`else
      TMR_OFF_MTIME_HI: rd_data_s = mtime_q[63:32];
`endif
      TMR_OFF_CMP_LO:   rd_data_s = cmp_q[31:0];
      TMR_OFF_CMP_HI:   rd_data_s = cmp_q[63:32];
      TMR_OFF_CTRL:     rd_data_s = ctrl_word_s;
      default:          rd_data_s = 32'd0;
    endcase
  end

  // Register next state: tick increments mtime, a bus write to mtime overrides it
  always_comb begin
    mtime_d = mtime_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    div_d   = div_q;
    if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
    if (wr_any_s) begin
      case (off_s)
        TMR_OFF_MTIME_LO: mtime_d = {mtime_q[63:32], wb_merge(mtime_q[31:0], i_wb.data, i_wb.sel)};
        TMR_OFF_MTIME_HI: mtime_d = {wb_merge(mtime_q[63:32], i_wb.data, i_wb.sel), mtime_q[31:0]};
        TMR_OFF_CMP_LO:   cmp_d   = {cmp_q[63:32], wb_merge(cmp_q[31:0], i_wb.data, i_wb.sel)};
        TMR_OFF_CMP_HI:   cmp_d   = {wb_merge(cmp_q[63:32], i_wb.data, i_wb.sel), cmp_q[31:0]};
        TMR_OFF_CTRL: begin
          en_d  = ctrl_new_s[TMR_CTRL_EN];
          div_d = ctrl_new_s[TMR_CTRL_DIV_LSB +: PRESCALE_W];
        end
        default: begin
          cmp_d = cmp_q;
        end
      endcase
    end else begin
      cmp_d = cmp_q;
    end
  end

`ifdef TIMER_SNAPSHOT_EN
  // Shadow of mtime_hi: captured on a lo read, overwritten by a hi write
  always_comb begin
    shadow_d = shadow_q;
    if (ack_next_s && !i_wb.we && (off_s == TMR_OFF_MTIME_LO)) begin
      shadow_d = mtime_q[63:32];
    end else if (wr_any_s && (off_s == TMR_OFF_MTIME_HI)) begin
      shadow_d = wb_merge(shadow_q, i_wb.data, i_wb.sel);
    end else begin
      shadow_d = shadow_q;
    end
  end
`endif

  // Bus response and interrupt next state
  always_comb begin
    ack_d  = ack_next_s;
    data_d = data_q;
    irq_d  = en_q & (mtime_q >= cmp_q);
    if (ack_next_s) begin
      data_d = rd_data_s;
    end else begin
      data_d = data_q;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mtime_q  <= 64'd0;
      cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q     <= 1'b0;
      div_q    <= '0;
      data_q   <= 32'd0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
`ifdef TIMER_SNAPSHOT_EN
      shadow_q <= 32'd0;
`endif
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      en_q     <= en_d;
      div_q    <= div_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      irq_q    <= irq_d;
`ifdef TIMER_SNAPSHOT_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign o_wb.data = data_q;
  assign o_wb.ack  = ack_q;
  assign o_irq     = irq_q;

endmodule

// File: tb/tb_wb_timer_slave.sv
// Scoreboard bench for wb_timer_slave: bus tasks push the expected read
// data per transaction, a monitor pops and compares on every ack.
module tb_wb_timer_slave;
  import wb_timer_slave_pkg::*;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic    clk = 1'b0;
  logic    rstn;
  wb_m2s_t wbm;
  wb_s2m_t wbs;
  logic    irq;
  logic    irq_at_ack;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  bit          chk_q[$];

  always #5 clk = ~clk;

  wb_timer_slave #(
    .BASE_ADDR  (BASE),
    .PRESCALE_W (8)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_wb   (wbm),
    .o_wb   (wbs),
    .o_irq  (irq)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry
  always @(negedge clk) begin : mon
    logic [31:0] e;
    bit          c;
    if (rstn === 1'b1 && wbs.ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=1 data=%h, expected no ack at %0t", wbs.data, $time);
      end else begin
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        if (c) check("rd_data", {32'd0, wbs.data}, {32'd0, e});
      end
    end
  end

  // One single-beat transaction, then one idle cycle
  task automatic xfer(input logic [2:0] off, input logic we, input logic [31:0] wdata,
                      input logic [3:0] sel, input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    wbm.addr = BASE | {27'd0, off, 2'b00};
    wbm.data = wdata;
    wbm.sel  = sel;
    wbm.we   = we;
    wbm.cyc  = 1'b1;
    wbm.stb  = 1'b1;
    exp_q.push_back(exp);
    chk_q.push_back(!we);
    do begin
      @(posedge clk); #1;
      n++;
    end while (wbs.ack !== 1'b1 && n < 8);
    check("ack_latency", n, 64'd1);
    if (wbs.ack !== 1'b1) begin
      void'(exp_q.pop_back());
      void'(chk_q.pop_back());
    end
    irq_at_ack = irq;
    wbm.cyc = 1'b0;
    wbm.stb = 1'b0;
    wbm.we  = 1'b0;
    @(posedge clk); #1;
    check("ack_single", {63'd0, wbs.ack}, 64'd0);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] sel);
    xfer(off, 1'b1, d, sel, 32'd0);
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] e);
    xfer(off, 1'b0, 32'd0, 4'hF, e);
  endtask

  task automatic read_reset_values();
    rd(3'd0, 32'd0);
    rd(3'd1, 32'd0);
    rd(3'd2, 32'hFFFF_FFFF);
    rd(3'd3, 32'hFFFF_FFFF);
    rd(3'd4, 32'd0);
    check("irq_after_reset", {63'd0, irq}, 64'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    int         w;
    rstn = 1'b0;
    wbm  = '0;
    irq_at_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",  {63'd0, wbs.ack}, 64'd0);
    check("rst_data", {32'd0, wbs.data}, 64'd0);
    check("rst_irq",  {63'd0, irq}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    read_reset_values();

    // Enable with div=0: ticks on every edge after the ctrl write
    wr(3'd4, 32'h0000_0001, 4'hF);
    repeat (10) @(posedge clk);
    rd(3'd0, 32'd11);

    // div=3: one tick every 4 cycles
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd0, 32'd0, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd4, 32'h0000_0301, 4'hF);
    repeat (9) @(posedge clk);
    rd(3'd0, 32'd2);
    rd(3'd0, 32'd3);

    // Interrupt at mtime == 20, then cleared by raising mtimecmp
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd0, 32'd0, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd3, 32'd0, 4'hF);
    wr(3'd2, 32'd20, 4'hF);
    wr(3'd4, 32'h0000_0001, 4'hF);
    repeat (18) @(posedge clk);
    #1;
    check("irq_mtime19", {63'd0, irq}, 64'd0);
    @(posedge clk); #1;
    check("irq_mtime20_same_cycle", {63'd0, irq}, 64'd0);
    @(posedge clk); #1;
    check("irq_rise", {63'd0, irq}, 64'd1);
    wr(3'd2, 32'hFFFF_FFFF, 4'hF);
    check("irq_still_high_at_ack", {63'd0, irq_at_ack}, 64'd1);
    check("irq_fall", {63'd0, irq}, 64'd0);

    // Byte-lane write coincident with ticks (div=1, ticks on even edges)
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd4, 32'h0000_0101, 4'hF);
    wr(3'd0, 32'hAAAA_AAAA, 4'hF);
    wr(3'd0, 32'h1234_5678, 4'b0011);
    rd(3'd0, 32'hAAAA_5678);
    rd(3'd1, 32'd0);

    // 64-bit wrap
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd0, 32'hFFFF_FFFF, 4'hF);
    wr(3'd1, 32'hFFFF_FFFF, 4'hF);
    rd(3'd0, 32'hFFFF_FFFF);
    rd(3'd1, 32'hFFFF_FFFF);
    wr(3'd4, 32'h0000_0001, 4'hF);
    rd(3'd0, 32'd0);
    rd(3'd1, 32'd0);

    // Address outside the block: never acked
    @(negedge clk);
    wbm.addr = 32'h0300_0000;
    wbm.sel  = 4'hF;
    wbm.cyc  = 1'b1;
    wbm.stb  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("nohit_ack", {63'd0, wbs.ack}, 64'd0);
    end
    wbm.cyc = 1'b0;
    wbm.stb = 1'b0;

    // Reserved offset reads zero and is acked
    rd(3'd6, 32'd0);

    // stb held: acks on alternate cycles only
    @(negedge clk);
    wbm.addr = BASE | 32'h0000_0008;
    wbm.sel  = 4'hF;
    wbm.we   = 1'b0;
    wbm.cyc  = 1'b1;
    wbm.stb  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'hFFFF_FFFF);
      chk_q.push_back(1'b1);
    end
    pat = 6'b010101;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("b2b_ack", {63'd0, wbs.ack}, {63'd0, pat[i]});
    end
    wbm.cyc = 1'b0;
    wbm.stb = 1'b0;
    @(posedge clk); #1;

    // Lo then hi read across the 32-bit carry
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd0, 32'hFFFF_FFFE, 4'hF);
    wr(3'd4, 32'h0000_0001, 4'hF);
    rd(3'd0, 32'hFFFF_FFFF);
`ifdef TIMER_SNAPSHOT_EN
    rd(3'd1, 32'd0);
`else
    rd(3'd1, 32'd1);
`endif

    // Reset asserted during an outstanding request
    rd(3'd2, 32'hFFFF_FFFF);
    check("irq_before_reset", {63'd0, irq}, 64'd1);
    @(negedge clk);
    wbm.addr = BASE;
    wbm.sel  = 4'hF;
    wbm.cyc  = 1'b1;
    wbm.stb  = 1'b1;
    #2;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_ack",  {63'd0, wbs.ack}, 64'd0);
      check("midrst_data", {32'd0, wbs.data}, 64'd0);
      check("midrst_irq",  {63'd0, irq}, 64'd0);
    end
    wbm.cyc = 1'b0;
    wbm.stb = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    read_reset_values();

    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    check("scoreboard_drained", exp_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
